// File: rtl/regfile_mp.sv
// Multi-read-port integer register file: x0 hardwired to zero, optional write-to-read
// bypass, per-register busy scoreboard, and a sequential clear sweep so the array needs no reset.
module regfile_mp #(
    parameter int unsigned  XLEN   = 32,
    parameter int unsigned  NREGS  = 32,
    parameter int unsigned  NREAD  = 2,
    parameter int unsigned  BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic                  clr_req,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic w_wr_acc;
    logic w_sb_acc;

    assign w_wr_acc = ready && wr_en && (wr_addr != '0);
    assign w_sb_acc = ready && sb_set && (sb_addr != '0);

    // Sweep / run control; ready mirrors the RUN state as a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= AW'(1);
            ready   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_cnt == AW'(NREGS - 1)) begin
                        r_state <= S_RUN;
                        ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                S_RUN: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= AW'(1);
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= AW'(1);
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the array while not ready; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!ready) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: a new producer (set) takes priority over a retiring write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else if (!ready || clr_req) begin
            r_busy <= '0;
        end else begin
            if (w_wr_acc) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_sb_acc) begin
                r_busy[sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = rd_addr[k*AW +: AW];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (ready && (w_addr != '0)) begin
                w_busy = r_busy[w_addr];
                if ((BYPASS != 0) && wr_en && (wr_addr == w_addr)) begin
                    w_data = wr_data;
                end else begin
                    w_data = r_mem[w_addr];
                end
            end
        end

        assign rd_data[k*XLEN +: XLEN] = w_data;
        assign rd_busy[k]              = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance (32x32, 2 ports, bypass) and a
// 16-entry, 4-port, no-bypass instance sharing clock and reset.
module tb_regfile_mp;

    logic         clk;
    logic         reset_n;

    logic         ready;
    logic         clr_req;
    logic [9:0]   rd_addr;
    logic [63:0]  rd_data;
    logic [1:0]   rd_busy;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         sb_set;
    logic [4:0]   sb_addr;

    logic         b_ready;
    logic         b_clr_req;
    logic [15:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic         b_sb_set;
    logic [3:0]   b_sb_addr;

    int checks   = 0;
    int failures = 0;
    int n0, n1, n;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .clr_req(clr_req),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(4), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .ready(b_ready), .clr_req(b_clr_req),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges from now until each instance reports ready (0 = never within bound).
    task automatic sweep_len(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready && c0 == 0) c0 = i;
            if (b_ready && c1 == 0) c1 = i;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        clr_req   = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        sb_set    = 1'b0;
        sb_addr   = '0;
        b_clr_req = 1'b0;
        b_rd_addr = '0;
        b_wr_en   = 1'b0;
        b_wr_addr = '0;
        b_wr_data = '0;
        b_sb_set  = 1'b0;
        b_sb_addr = '0;

        // Reset state
        repeat (3) tick();
        rd_addr = {5'd5, 5'd3};
        #1;
        check("reset_ready", 128'(ready), 128'd0);
        check("reset_rd_data", 128'(rd_data), 128'd0);
        check("reset_rd_busy", 128'(rd_busy), 128'd0);
        check("reset_b_ready", 128'(b_ready), 128'd0);

        // Initial sweep length
        reset_n = 1'b1;
        sweep_len(n0, n1);
        check("sweep_len_32", 128'(n0), 128'd31);
        check("sweep_len_16", 128'(n1), 128'd15);

        for (int a = 0; a < 32; a++) begin
            rd_addr[4:0] = 5'(a);
            rd_addr[9:5] = 5'(31 - a);
            #1;
            check("post_sweep_zero", 128'(rd_data), 128'd0);
        end
        b_rd_addr = {4'd15, 4'd2, 4'd1, 4'd0};
        #1;
        check("b_post_sweep_zero", b_rd_data, 128'd0);

        // Write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr = '0;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd5, 5'd5};
        #1;
        check("x5_both_ports", 128'(rd_data), {64'd0, 32'hDEADBEEF, 32'hDEADBEEF});

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_addr = {5'd5, 5'd0};
        #1;
        check("x0_no_bypass", 128'(rd_data[31:0]), 128'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("x0_reads_zero", 128'(rd_data[31:0]), 128'd0);

        // Same-cycle bypass (bypass instance)
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd7, 5'd7};
        #1;
        check("bypass_x7", 128'(rd_data), {64'd0, 32'hA5A5A5A5, 32'hA5A5A5A5});
        tick();
        wr_en = 1'b0;
        #1;
        check("stored_x7", 128'(rd_data[31:0]), 128'h0000_0000_A5A5_A5A5);

        // No bypass on the second instance: old value until the edge
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 32'h11111111;
        tick();
        b_wr_data = 32'hA5A5A5A5;
        b_rd_addr = {4'd7, 4'd0, 4'd0, 4'd7};
        #1;
        check("b_nobypass_old", b_rd_data, {32'h11111111, 32'd0, 32'd0, 32'h11111111});
        tick();
        b_wr_en = 1'b0;
        #1;
        check("b_after_write", b_rd_data, {32'hA5A5A5A5, 32'd0, 32'd0, 32'hA5A5A5A5});

        // Scoreboard set / clear / set-wins
        sb_set = 1'b1; sb_addr = 5'd9;
        rd_addr = {5'd8, 5'd9};
        #1;
        check("busy_not_bypassed", 128'(rd_busy), 128'd0);
        tick();
        sb_set = 1'b0;
        #1;
        check("busy_set_x9", 128'(rd_busy), 128'b01);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        wr_en = 1'b0;
        #1;
        check("busy_clr_x9", 128'(rd_busy), 128'b00);
        check("data_x9", 128'(rd_data[31:0]), 128'h99);
        sb_set = 1'b1; sb_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
        tick();
        sb_set = 1'b0; wr_en = 1'b0;
        #1;
        check("busy_set_wins", 128'(rd_busy), 128'b01);
        check("data_x9_set_wins", 128'(rd_data[31:0]), 128'h77);
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("busy_x0_ignored", 128'(rd_busy), 128'b00);

        b_sb_set = 1'b1; b_sb_addr = 4'd3;
        tick();
        b_sb_set = 1'b0;
        b_rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
        #1;
        check("b_busy_shared_addr", 128'(b_rd_busy), 128'b1111);

        // Clear sweep on request with traffic during the sweep
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        wr_en = 1'b0; sb_set = 1'b0;
        rd_addr = {5'd4, 5'd3};
        #1;
        check("pre_clr_x3", 128'(rd_data[31:0]), 128'h33);
        check("pre_clr_busy_x4", 128'(rd_busy), 128'b10);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_ready_low", 128'(ready), 128'd0);
        n = 0;
        while (!ready && n < 40) begin
            wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
            sb_set = 1'b1; sb_addr = 5'd6;
            clr_req = (n == 5);
            tick();
            n++;
        end
        wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
        check("clr_sweep_len", 128'(n), 128'd31);
        rd_addr = {5'd6, 5'd3};
        #1;
        check("post_clr_data", 128'(rd_data), 128'd0);
        check("post_clr_busy_x6", 128'(rd_busy), 128'b00);
        rd_addr = {5'd4, 5'd9};
        #1;
        check("post_clr_busy_x4_x9", 128'(rd_busy), 128'b00);
        check("post_clr_x9", 128'(rd_data[31:0]), 128'd0);

        // Reset mid-sweep restarts the full sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        check("midsweep_reset_ready", 128'(ready), 128'd0);
        tick();
        reset_n = 1'b1;
        sweep_len(n0, n1);
        check("restart_sweep_32", 128'(n0), 128'd31);
        check("restart_sweep_16", 128'(n1), 128'd15);
        b_rd_addr = {4'd3, 4'd3, 4'd7, 4'd7};
        #1;
        check("b_restart_busy", 128'(b_rd_busy), 128'd0);
        check("b_restart_data", b_rd_data, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
